// File: rtl/shift_reg_unit.sv
// Universal WIDTH-bit shift register: hold, parallel load, logical/arithmetic shift
// and rotate, either one step per clock or as a counted multi-cycle operation.
module shift_reg_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    // Handshake: start with a shift/rotate mode is accepted at any edge where busy=0;
    // busy then stays high while steps run and done pulses for one cycle at the end.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_d;
    logic             busy_d, done_d;

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] load,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (m)
            3'b001:  r = load;
            3'b010:  r = {v[WIDTH-2:0], sr};
            3'b011:  r = {sl, v[WIDTH-1:1]};
            3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b101:  r = {v[0], v[WIDTH-1:1]};
            3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic is_counted(input logic [2:0] m);
        return (m != 3'b000) && (m != 3'b001) && (m != 3'b111);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        q_d     = q;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_counted(mode)) begin
                    // Acceptance edge only latches the operation; q moves from the next edge.
                    op_d  = mode;
                    cnt_d = amount;
                    if (amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    q_d = apply_mode(mode, q, data_in, ser_in_l, ser_in_r);
                end
            end
            RUN: begin
                q_d   = apply_mode(op_q, q, data_in, ser_in_l, ser_in_r);
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            q       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q       <= q_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Self-checking bench for shift_reg_unit: directed scenarios with literal values
// plus randomized traffic compared every cycle against a behavioural model.
module tb_shift_reg_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clock;
    logic             clear;
    logic [2:0]       mode;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             ser_in_l;
    logic             ser_in_r;
    logic [WIDTH-1:0] q;
    logic             ser_out_l;
    logic             ser_out_r;
    logic             busy;
    logic             done;
    logic             state_dbg;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    shift_reg_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .mode      (mode),
        .start     (start),
        .amount    (amount),
        .data_in   (data_in),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .q         (q),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: value as plain integer arithmetic, op as a remaining-step count
    int   m_q    = 0;
    int   m_left = 0;
    int   m_op   = 0;
    logic m_done = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    function automatic int model_step(input int m, input int x, input int load, input int sl, input int sr);
        int mask = (1 << WIDTH) - 1;
        int msb  = 1 << (WIDTH - 1);
        case (m)
            1:       return load;
            2:       return ((x << 1) | sr) & mask;
            3:       return (x >> 1) | (sl * msb);
            4:       return ((x << 1) | (x >> (WIDTH - 1))) & mask;
            5:       return (x >> 1) | ((x & 1) * msb);
            6:       return (x >> 1) | (x & msb);
            default: return x;
        endcase
    endfunction

    always @(posedge clock) begin
        if (!clear) begin
            m_q = 0; m_left = 0; m_op = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_q = model_step(m_op, m_q, int'(data_in), int'(ser_in_l), int'(ser_in_r));
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (start && mode >= 3'd2 && mode <= 3'd6) begin
                m_op   = int'(mode);
                m_left = int'(amount);
                if (amount == 0) m_done = 1'b1;
            end else begin
                m_q = model_step(int'(mode), m_q, int'(data_in), int'(ser_in_l), int'(ser_in_r));
            end
        end
        exp_q.push_back(WIDTH'(m_q));
    end

    // scoreboard: compare every cycle away from the active edge
    always @(negedge clock) begin
        logic [WIDTH-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (chk_en) begin
                check("q", 32'(q), 32'(e));
                check("busy", 32'(busy), 32'(m_left > 0));
                check("done", 32'(done), 32'(m_done));
                check("state_dbg", 32'(state_dbg), 32'(m_left > 0));
                check("ser_out_l", 32'(ser_out_l), 32'(e[WIDTH-1]));
                check("ser_out_r", 32'(ser_out_r), 32'(e[0]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        start = 1'b0; mode = 3'b000; amount = '0;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        mode = 3'b001; data_in = v; start = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic lit(input string name, input logic [31:0] dut_val, input logic [31:0] model_val,
                       input logic [31:0] exp);
        check({name, "_dut"}, dut_val, exp);
        check({name, "_model"}, model_val, exp);
    endtask

    task automatic launch(input logic [2:0] m, input logic [CNT_W-1:0] n);
        mode = m; amount = n; start = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        clear = 1'b0; mode = 3'($urandom_range(0, 7)); start = 1'b1; amount = 4'd5;
        data_in = 8'h3C; ser_in_l = 1'b1; ser_in_r = 1'b1;
        @(negedge clock);
        tick();
        tick();
        chk_en = 1'b1;
        lit("reset_q", 32'(q), 32'(m_q), 32'h00);
        lit("reset_busy", 32'(busy), 32'(m_left > 0), 32'd0);
        lit("reset_done", 32'(done), 32'(m_done), 32'd0);
        clear = 1'b1; idle_inputs(); ser_in_l = 1'b0; ser_in_r = 1'b0;

        load(8'hA5);
        lit("load_a5", 32'(q), 32'(m_q), 32'hA5);

        // rotate left by 3
        launch(3'b100, 4'd3);
        lit("rol_busy", 32'(busy), 32'(m_left > 0), 32'd1);
        lit("rol_hold", 32'(q), 32'(m_q), 32'hA5);
        tick(); lit("rol_1", 32'(q), 32'(m_q), 32'h4B);
        tick(); lit("rol_2", 32'(q), 32'(m_q), 32'h96);
        tick(); lit("rol_3", 32'(q), 32'(m_q), 32'h2D);
        lit("rol_done", 32'(done), 32'(m_done), 32'd1);
        lit("rol_busy_off", 32'(busy), 32'(m_left > 0), 32'd0);
        tick(); lit("rol_done_off", 32'(done), 32'(m_done), 32'd0);

        // arithmetic right by 2
        load(8'h90);
        launch(3'b110, 4'd2);
        tick(); lit("asr_1", 32'(q), 32'(m_q), 32'hC8);
        tick(); lit("asr_2", 32'(q), 32'(m_q), 32'hE4);
        lit("asr_done", 32'(done), 32'(m_done), 32'd1);
        tick();

        // single-step left with ser_in_r=1
        load(8'h00);
        mode = 3'b010; ser_in_r = 1'b1;
        tick(); lit("ssl_1", 32'(q), 32'(m_q), 32'h01);
        tick(); lit("ssl_2", 32'(q), 32'(m_q), 32'h03);
        tick(); lit("ssl_3", 32'(q), 32'(m_q), 32'h07);
        lit("ssl_busy", 32'(busy), 32'(m_left > 0), 32'd0);
        idle_inputs(); ser_in_r = 1'b0;

        // zero amount
        launch(3'b101, 4'd0);
        lit("zero_done", 32'(done), 32'(m_done), 32'd1);
        lit("zero_q", 32'(q), 32'(m_q), 32'h07);
        lit("zero_busy", 32'(busy), 32'(m_left > 0), 32'd0);
        tick(); lit("zero_done_off", 32'(done), 32'(m_done), 32'd0);

        // interference during RUN: rotate right 5 of 3C must give E1
        load(8'h3C);
        launch(3'b101, 4'd5);
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1)); mode = 3'($urandom_range(0, 7));
            amount = 4'($urandom_range(0, 15)); data_in = 8'($urandom_range(0, 255));
            tick();
        end
        idle_inputs();
        tick(); lit("intf_q", 32'(q), 32'(m_q), 32'hE1);
        lit("intf_done", 32'(done), 32'(m_done), 32'd1);
        tick();

        // rotate by WIDTH and logical shift beyond WIDTH
        load(8'h5A);
        launch(3'b100, 4'd8);
        repeat (8) tick();
        lit("rol8", 32'(q), 32'(m_q), 32'h5A);
        ser_in_l = 1'b1;
        launch(3'b011, 4'd12);
        repeat (12) tick();
        lit("shr12", 32'(q), 32'(m_q), 32'hFF);
        ser_in_l = 1'b0;
        tick();

        // reset mid-RUN
        launch(3'b010, 4'd10);
        repeat (3) tick();
        clear = 1'b0;
        tick();
        lit("midrst_q", 32'(q), 32'(m_q), 32'h00);
        lit("midrst_busy", 32'(busy), 32'(m_left > 0), 32'd0);
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_no_done", 32'(done), 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            clear    = ($urandom_range(0, 49) != 0);
            start    = ($urandom_range(0, 3) == 0);
            mode     = 3'($urandom_range(0, 7));
            amount   = 4'($urandom_range(0, 15));
            data_in  = 8'($urandom_range(0, 255));
            ser_in_l = 1'($urandom_range(0, 1));
            ser_in_r = 1'($urandom_range(0, 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
